// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from two 4-deep byte FIFOs (A = echo, B = console).
// Push-to-txStart latency is 2 cycles; a push into a full FIFO is dropped and flags err[0], never stalls the writer.
module uart_tx_arbiter #(
  parameter int ADDR_W      = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic [7:0] aWrData,
  input  logic       aWrEn,
  output logic       aFull,
  input  logic [7:0] bWrData,
  input  logic       bWrEn,
  output logic       bFull,
  output logic [7:0] txData,
  output logic       txStart,
  input  logic       txBusy,
  output logic       activeCh,
  output logic       busy,
  output logic [1:0] err,
  input  logic       clrErr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, ACK, DONE} state_t;

  state_t            state;
  logic              last_grant;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [7:0]        mem [2][DEPTH];
  logic [ADDR_W-1:0] wr_ptr [2];
  logic [ADDR_W-1:0] rd_ptr [2];
  logic [ADDR_W:0]   count [2];
  logic [ADDR_W:0]   count_next [2];
  logic [7:0]        wr_data [2];
  logic [1:0]        full_q;
  logic [1:0]        wr_en;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        nonempty;

  logic              take;
  logic              grant_b;
  logic [7:0]        head;
  logic              overflow;
  logic              timeout_hit;
  logic [1:0]        err_next;

  assign wr_en      = {bWrEn, aWrEn};
  assign wr_data[0] = aWrData;
  assign wr_data[1] = bWrData;
  assign aFull      = full_q[0];
  assign bFull      = full_q[1];

  // Tie goes to the channel that did not win last; otherwise whoever has data.
  assign take    = (state == IDLE) && (|nonempty);
  assign grant_b = (&nonempty) ? ~last_grant : nonempty[1];
  assign head    = mem[grant_b][rd_ptr[grant_b]];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      nonempty[c]   = (count[c] != '0);
      push[c]       = wr_en[c] && !full_q[c];
      pop[c]        = take && (grant_b == c[0]);
      count_next[c] = count[c];
      if (push[c] && !pop[c])
        count_next[c] = count[c] + 1'b1;
      else if (pop[c] && !push[c])
        count_next[c] = count[c] - 1'b1;
    end
  end

  // The full flag is the registered one, so a pop in the same cycle cannot rescue a push.
  assign overflow    = |(wr_en & full_q);
  assign timeout_hit = (state == ACK) && !txBusy && (tmo_cnt == TMO_LAST);
  assign err_next    = (clrErr ? 2'b00 : err) | {timeout_hit, overflow};

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      full_q <= 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c])
          wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
        count[c]  <= count_next[c];
        full_q[c] <= (count_next[c] == FULL_CNT);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c])
        mem[c][wr_ptr[c]] <= wr_data[c];
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      txData     <= 8'h00;
      txStart    <= 1'b0;
      activeCh   <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      tmo_cnt    <= '0;
      err        <= 2'b00;
    end else begin
      txStart <= 1'b0;
      err     <= err_next;
      case (state)
        IDLE: begin
          if (take) begin
            txData     <= head;
            activeCh   <= grant_b;
            last_grant <= grant_b;
            txStart    <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= ACK;
        end
        ACK: begin
          if (txBusy) begin
            state <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!txBusy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
